// File: rtl/cla_4_if.sv
// cla_4 operand/result bundle.
// master drives A/B/Cin; slave returns the registered results.
interface cla_4_if;
    logic       Cin;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Sum;
    logic [3:0] Generate;
    logic [3:0] Propogate;
    logic       Cout;
    logic       GG;
    logic       GP;

    modport master (
        output Cin, A, B,
        input  Sum, Generate, Propogate, Cout, GG, GP
    );

    modport slave (
        input  Cin, A, B,
        output Sum, Generate, Propogate, Cout, GG, GP
    );
endinterface

// File: rtl/cla_4.sv
// cla_4: registered 4-bit carry-lookahead slice with group g/p outputs.
// Optional input register stage: define CLA_4_IN_REG_EN (latency 2).
module cla_4 (
    input logic   clk,
    input logic   rst_n,
    cla_4_if.slave io
);

    logic [3:0] a;
    logic [3:0] b;
    logic       cin;

`ifdef CLA_4_IN_REG_EN
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       cin_q;

    // capture operands ahead of the lookahead core
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= io.A;
            b_q   <= io.B;
            cin_q <= io.Cin;
        end
    end

    assign a   = a_q;
    assign b   = b_q;
    assign cin = cin_q;
`else
    assign a   = io.A;
    assign b   = io.B;
    assign cin = io.Cin;
`endif

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] s;
    logic       gg;
    logic       gp;

    // flat two-level lookahead: every carry straight from g/p/cin
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        c[0] = cin;
        c[1] = g[0]
             | (p[0] & cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        gg = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
        gp = &p;
        s  = p ^ c[3:0];
    end

    // output register; reset forces every result to zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io.Sum       <= '0;
            io.Generate  <= '0;
            io.Propogate <= '0;
            io.Cout      <= 1'b0;
            io.GG        <= 1'b0;
            io.GP        <= 1'b0;
        end else begin
            io.Sum       <= s;
            io.Generate  <= g;
            io.Propogate <= p;
            io.Cout      <= c[4];
            io.GG        <= gg;
            io.GP        <= gp;
        end
    end

endmodule

// File: tb/tb_cla_4.sv
// tb_cla_4: randomized and directed checks of cla_4 against an
// arithmetic reference model with latency/reset history tracking.
module tb_cla_4;

`ifdef CLA_4_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;

    cla_4_if io ();

    cla_4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // applied-input history, index 0 = most recent edge
    logic       h_rst [2];
    logic [3:0] h_a   [2];
    logic [3:0] h_b   [2];
    logic       h_c   [2];

    // reference: plain arithmetic, packed {Cout,Sum,G,P,GG,GP}
    function automatic logic [14:0] model(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin
    );
        int          s;
        int          s0;
        logic [3:0]  p;
        logic [4:0]  s5;
        s  = int'(a) + int'(b) + int'(cin);
        s0 = int'(a) + int'(b);
        p  = a ^ b;
        s5 = s[4:0];
        return {s5[4], s5[3:0], a & b, p,
                (s0 > 15) ? 1'b1 : 1'b0,
                (p == 4'hF) ? 1'b1 : 1'b0};
    endfunction

    function automatic logic [14:0] expected();
        logic z;
        int   k;
        z = h_rst[0];
        if (LAT > 1) z = z | h_rst[1];
        k = LAT - 1;
        if (z) return '0;
        return model(h_a[k], h_b[k], h_c[k]);
    endfunction

    function automatic logic [14:0] observed();
        return {io.Cout, io.Sum, io.Generate, io.Propogate,
                io.GG, io.GP};
    endfunction

    task automatic apply(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin,
        input logic       rn
    );
        io.A   = a;
        io.B   = b;
        io.Cin = cin;
        rst_n  = rn;
        @(posedge clk);
        h_rst[1] = h_rst[0];
        h_a[1]   = h_a[0];
        h_b[1]   = h_b[0];
        h_c[1]   = h_c[0];
        h_rst[0] = ~rn;
        h_a[0]   = a;
        h_b[0]   = b;
        h_c[0]   = cin;
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] exp_v;
        for (int i = 0; i < 3; i++) begin
            apply(4'hF, 4'hF, 1'b1, 1'b0);
            n_run++;
            if (observed() !== 15'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got %h want %h",
                         observed(), 15'd0);
            end
        end
        for (int i = 0; i < LAT; i++) begin
            apply(4'hF, 4'hF, 1'b1, 1'b1);
            exp_v = expected();
            n_run++;
            if (observed() !== exp_v) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: got %h want %h",
                         i, observed(), exp_v);
            end
        end
        n_run++;
        if (observed() !== 15'b1_1111_1111_0000_1_0) begin
            n_fail++;
            $display("FAIL reset_first_result: got %h want %h",
                     observed(), 15'b1_1111_1111_0000_1_0);
        end
    endtask

    task automatic test_vectors();
        logic [3:0]  ta [5] = '{4'hF, 4'h8, 4'hF, 4'h1, 4'hF};
        logic [3:0]  tb [5] = '{4'h1, 4'h8, 4'h8, 4'h2, 4'h0};
        logic [14:0] te [5] = '{
            15'b1_0001_0001_1110_1_0,
            15'b1_0001_1000_0000_1_0,
            15'b1_1000_1000_0111_1_0,
            15'b0_0100_0000_0011_0_0,
            15'b1_0000_0000_1111_0_1
        };
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < LAT; j++)
                apply(ta[i], tb[i], 1'b1, 1'b1);
            n_run++;
            if (observed() !== te[i]) begin
                n_fail++;
                $display("FAIL vector[%0d]: got %h want %h",
                         i, observed(), te[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  v;
        logic [14:0] exp_v;
        for (int i = 0; i < 512 + LAT; i++) begin
            v = 9'(i);
            if (i >= 512) v = 9'($urandom);
            apply(v[8:5], v[4:1], v[0], (i == 200) ? 1'b0 : 1'b1);
            exp_v = expected();
            n_run++;
            if (observed() !== exp_v) begin
                n_fail++;
                $display("FAIL sweep[%0d]: got %h want %h",
                         i, observed(), exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [14:0] exp_v;
        logic        rn;
        for (int i = 0; i < 300; i++) begin
            rn = ($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1;
            apply(4'($urandom), 4'($urandom), 1'($urandom), rn);
            exp_v = expected();
            n_run++;
            if (observed() !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h",
                         i, observed(), exp_v);
            end
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        h_rst  = '{1'b1, 1'b1};
        h_a    = '{4'h0, 4'h0};
        h_b    = '{4'h0, 4'h0};
        h_c    = '{1'b0, 1'b0};
        io.A   = '0;
        io.B   = '0;
        io.Cin = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
